audio_dac_serializer: RTL and testbench

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

---
 rtl/audio_pkg.sv | 14 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/audio_dac_serializer.sv | 168 ++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - format enum and default constants for the audio DAC serializer
package audio_pkg;

  typedef enum logic {
    FMT_LJ  = 1'b0,
    FMT_I2S = 1'b1
  } fmt_e;

  localparam int SAMPLE_W_DEF   = 16;
  localparam int SLOT_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int BCLK_HALF_DEF  = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with full/empty/level status
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - stereo frame FIFO to I2S / left-justified codec serializer
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int SLOT_W     = SLOT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int BCLK_HALF  = BCLK_HALF_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_left,
  input  logic [SAMPLE_W-1:0]           s_right,
  input  logic                          mute,
  input  logic                          fmt_i2s,
  output logic                          bclk,
  output logic                          lrck,
  output logic                          dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underflow_cnt
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = $clog2(BCLK_HALF);
  localparam int BIT_W = $clog2(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);

  logic                  started_q, started_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic                  lrck_q, lrck_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [SLOT_W-1:0]     sr_q, sr_d;
  logic [SAMPLE_W-1:0]   right_q, right_d;
  fmt_e                  fmt_q, fmt_d;
  logic                  lj_bit_q, lj_bit_d;
  logic                  dacdat_q, dacdat_d;
  logic                  s_ready_q, s_ready_d;
  logic [15:0]           ucnt_q, ucnt_d;

  logic                  push, pop, tick, fall, slot_end, frame_start;
  logic [2*SAMPLE_W-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [LVL_W-1:0]      fifo_lvl, lvl_next;
  logic [SAMPLE_W-1:0]   left_s;

  function automatic logic [SLOT_W-1:0] slot_word(input logic [SAMPLE_W-1:0] s);
    return SLOT_W'(s) << (SLOT_W - SAMPLE_W);
  endfunction

  sync_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data ({s_left, s_right}),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_lvl)
  );

  assign push     = s_valid && s_ready_q && !fifo_full;
  assign tick     = (div_q == DIV_LAST);
  assign fall     = tick && bclk_q;
  assign slot_end = fall && (bit_q == BIT_LAST);
  // The first cycle out of reset behaves like an lrck 1->0 edge.
  assign frame_start = !started_q || (slot_end && lrck_q);
  assign lvl_next    = fifo_lvl + LVL_W'(push) - LVL_W'(pop);

  always_comb begin
    started_d = 1'b1;
    div_d     = div_q + DIV_W'(1);
    bclk_d    = bclk_q;
    lrck_d    = lrck_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    right_d   = right_q;
    fmt_d     = fmt_q;
    lj_bit_d  = lj_bit_q;
    dacdat_d  = dacdat_q;
    ucnt_d    = ucnt_q;
    left_s    = '0;
    pop       = 1'b0;

    if (tick) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end
    if (fall) begin
      bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
      sr_d  = sr_q << 1;
    end
    if (slot_end && !lrck_q) begin
      lrck_d = 1'b1;
      sr_d   = slot_word(right_q);
    end
    if (frame_start) begin
      lrck_d = 1'b0;
      bclk_d = 1'b0;
      div_d  = '0;
      bit_d  = '0;
      fmt_d  = fmt_e'(fmt_i2s);
      right_d = '0;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (!mute) begin
          left_s  = fifo_rdata[2*SAMPLE_W-1:SAMPLE_W];
          right_d = fifo_rdata[SAMPLE_W-1:0];
        end
      end else if (ucnt_q != 16'hFFFF) begin
        ucnt_d = ucnt_q + 16'd1;
      end
      sr_d = slot_word(left_s);
    end
    // I2S replays the previous left-justified bit, giving the one-BCLK delay.
    if (fall || frame_start) begin
      lj_bit_d = sr_d[SLOT_W-1];
      dacdat_d = (fmt_d == FMT_I2S) ? lj_bit_q : lj_bit_d;
    end

    s_ready_d = (lvl_next != LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      started_q <= 1'b0;
      div_q     <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      bit_q     <= '0;
      sr_q      <= '0;
      right_q   <= '0;
      fmt_q     <= FMT_LJ;
      lj_bit_q  <= 1'b0;
      dacdat_q  <= 1'b0;
      s_ready_q <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      started_q <= started_d;
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      right_q   <= right_d;
      fmt_q     <= fmt_d;
      lj_bit_q  <= lj_bit_d;
      dacdat_q  <= dacdat_d;
      s_ready_q <= s_ready_d;
      ucnt_q    <= ucnt_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign bclk          = bclk_q;
  assign lrck          = lrck_q;
  assign dacdat        = dacdat_q;
  assign fifo_level    = fifo_lvl;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb/tb_audio_dac_serializer.sv - scoreboard bench for the audio DAC serializer
module tb_audio_dac_serializer;
  import audio_pkg::*;

  localparam int FRAME_CLKS = 2 * SLOT_W_DEF * 2 * BCLK_HALF_DEF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        mute = 1'b0;
  logic        fmt_i2s = 1'b0;
  logic [15:0] s_left = '0;
  logic [15:0] s_right = '0;
  logic        s_ready, bclk, lrck, dacdat;
  logic [3:0]  fifo_level;
  logic [15:0] underflow_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  logic [1:0] exp_q[$];
  logic prev_bclk = 1'b0;

  audio_dac_serializer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_left        (s_left),
    .s_right       (s_right),
    .mute          (mute),
    .fmt_i2s       (fmt_i2s),
    .bclk          (bclk),
    .lrck          (lrck),
    .dacdat        (dacdat),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every bclk rising edge presents one {lrck, dacdat} bit.
  always @(negedge clk) begin
    if (bclk && !prev_bclk && exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({lrck, dacdat} !== e) begin
        errors++;
        $display("FAIL serial_bit got lrck/dat=%b%b exp=%b at %0t", lrck, dacdat, e, $time);
      end
    end
    prev_bclk = bclk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  task automatic exp_frame(input logic [15:0] l, input logic [15:0] r, input logic i2s);
    logic [63:0] w;
    w = {l, 16'h0, r, 16'h0};
    for (int k = 0; k < 64; k++) begin
      logic b;
      if (i2s) b = (k == 0) ? 1'b0 : w[64-k];
      else     b = w[63-k];
      exp_q.push_back({(k >= 32) ? 1'b1 : 1'b0, b});
    end
  endtask

  task automatic do_reset(input int n);
    s_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_bclk", bclk, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_dacdat", dacdat, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ucnt", underflow_cnt, 0);
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_frame(16'h0, 16'h0, fmt_i2s);
    @(posedge clk); #1;
    t0 = cyc;
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_ucnt", underflow_cnt, 1);
    chk("post_rst_lrck", lrck, 0);
    chk("post_rst_level", fifo_level, 0);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int n;
    n = 0;
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      timeout("push");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_frame_start();
    logic p;
    p = lrck;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (p && !lrck) return;
      p = lrck;
    end
    timeout("frame_start");
  endtask

  task automatic wait_lrck_high();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (lrck) return;
    end
    timeout("lrck_high");
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    timeout("drain");
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Left-justified single frame
    fmt_i2s = 1'b0;
    do_reset(3);
    push(16'h8001, 16'h7FFE);
    exp_frame(16'h8001, 16'h7FFE, 1'b0);
    exp_frame(16'h0, 16'h0, 1'b0);
    wait_frame_start();
    chk("lj_f1_ucnt", underflow_cnt, 1);
    chk("lj_f1_level", fifo_level, 0);
    wait_frame_start();
    chk("lj_f2_ucnt", underflow_cnt, 2);
    drain(1500);

    // I2S single frame
    fmt_i2s = 1'b1;
    do_reset(2);
    push(16'h8001, 16'h7FFE);
    exp_frame(16'h8001, 16'h7FFE, 1'b1);
    exp_frame(16'h0, 16'h0, 1'b1);
    wait_frame_start();
    wait_frame_start();
    chk("i2s_f2_ucnt", underflow_cnt, 2);
    drain(1500);
    fmt_i2s = 1'b0;

    // Fill to full, ninth frame waits for the next pop
    do_reset(2);
    for (int i = 1; i <= 8; i++) begin
      push(16'(16'h1111 * i), 16'(~(16'h1111 * i)));
      exp_frame(16'(16'h1111 * i), 16'(~(16'h1111 * i)), 1'b0);
    end
    @(negedge clk);
    chk("full_level", fifo_level, 8);
    chk("full_s_ready", s_ready, 0);
    push(16'hC3A5, 16'h5A3C);
    exp_frame(16'hC3A5, 16'h5A3C, 1'b0);
    chk("ninth_accept_cycle", cyc - t0, FRAME_CLKS + 1);
    chk("ninth_level", fifo_level, 8);
    drain(12000);

    // Mute across a frame start with three frames queued
    do_reset(2);
    push(16'h1234, 16'h5678);
    push(16'h9ABC, 16'hDEF0);
    push(16'h0F0F, 16'hF0F0);
    mute = 1'b1;
    exp_frame(16'h0, 16'h0, 1'b0);
    exp_frame(16'h9ABC, 16'hDEF0, 1'b0);
    exp_frame(16'h0F0F, 16'hF0F0, 1'b0);
    wait_frame_start();
    mute = 1'b0;
    chk("mute_level", fifo_level, 2);
    chk("mute_ucnt", underflow_cnt, 1);
    wait_frame_start();
    wait_frame_start();
    chk("mute_f3_ucnt", underflow_cnt, 1);
    drain(1500);

    // Push landing on the same edge as a frame start, FIFO empty
    do_reset(2);
    exp_frame(16'h0, 16'h0, 1'b0);
    exp_frame(16'hA55A, 16'h0FF0, 1'b0);
    wait_lrck_high();
    repeat (FRAME_CLKS / 2 - 1) @(negedge clk);
    s_left  = 16'hA55A;
    s_right = 16'h0FF0;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("coinc_cycle", cyc - t0, FRAME_CLKS);
    chk("coinc_lrck", lrck, 0);
    chk("coinc_ucnt", underflow_cnt, 2);
    chk("coinc_level", fifo_level, 1);
    wait_frame_start();
    chk("coinc_next_level", fifo_level, 0);
    chk("coinc_next_ucnt", underflow_cnt, 2);
    drain(1500);

    // One-cycle reset in mid right slot with frames queued
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      push(16'(16'h2468 + i), 16'(16'h1357 + i));
      exp_frame(16'(16'h2468 + i), 16'(16'h1357 + i), 1'b0);
    end
    wait_frame_start();
    wait_lrck_high();
    repeat (100) @(negedge clk);
    chk("mid_level", fifo_level, 4);
    do_reset(1);
    wait_frame_start();
    chk("after_rst_ucnt", underflow_cnt, 2);
    chk("after_rst_level", fifo_level, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
